// File: rtl/ad7124_tc_frame_collector.sv
// ad7124_tc_frame_collector
// Collects 24-bit AD7124 data-register words into per-channel frames.
// Each word is assigned a channel by arrival order and converted from offset
// binary to two's complement. A full frame is published as a snapshot for
// software. Every word is also streamed as {ch,data} through a first-word
// fall-through FIFO toward the AXI/DMA side.

module ad7124_tc_frame_collector #(
  parameter int NUM_CH     = 8,
  parameter bit BIPOLAR    = 1'b1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  PL_clk,
  input  logic                  PL_USER_RST_N,
  input  logic                  frame_start,
  input  logic                  sample_valid,
  input  logic [23:0]           sample_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           m_data,
  output logic [24*NUM_CH-1:0]  frame_data,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic [3:0]            ch_idx,
  output logic                  overflow,
  input  logic                  clear_ovf
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  // Working bank: one slot per channel, filled as words arrive.
  logic [NUM_CH-1:0][23:0] bank;

  // Frame completion pipeline stage: last channel captured on the previous edge.
  logic frame_pend;

  // Stream FIFO storage and pointers (extra MSB distinguishes full from empty).
  logic [27:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic [23:0] conv;
  logic [3:0]  wr_ch;
  logic        last_word;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        drop;

  // Offset-binary to two's-complement conversion and channel/FIFO decisions.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    conv       = BIPOLAR ? {~sample_data[23], sample_data[22:0]} : sample_data;
    wr_ch      = frame_start ? 4'd0 : ch_idx;
    last_word  = sample_valid && (wr_ch == LAST_CH);
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = !fifo_empty && m_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push       = sample_valid && (!fifo_full || pop);
    drop       = sample_valid && fifo_full && !pop;
  end

  // First-word fall-through head: valid whenever the FIFO holds a word.
  always_comb begin
    m_valid = !fifo_empty;
    m_data  = fifo_empty ? 32'd0 : {4'h0, mem[rd_ptr[AW-1:0]]};
  end

  // Channel sequencing and working-bank capture.
  always_ff @(posedge PL_clk or negedge PL_USER_RST_N) begin
    if (!PL_USER_RST_N) begin
      ch_idx <= 4'd0;
      bank   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, so block order cannot change behaviour.
      if (sample_valid) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (wr_ch == 4'(k)) bank[k] <= conv;
        end
        ch_idx <= (wr_ch == LAST_CH) ? 4'd0 : wr_ch + 4'd1;
      end else if (frame_start) begin
        // Partial data stays in the bank and is overwritten by the next frame.
        ch_idx <= 4'd0;
      end
    end
  end

  // Snapshot publication one edge after the last channel lands in the bank.
  always_ff @(posedge PL_clk or negedge PL_USER_RST_N) begin
    if (!PL_USER_RST_N) begin
      frame_pend <= 1'b0;
      frame_done <= 1'b0;
      frame_data <= '0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_pend <= last_word;
      frame_done <= frame_pend;
      if (frame_pend) begin
        frame_data <= bank;
        frame_cnt  <= frame_cnt + 16'd1;
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge PL_clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    if (push) mem[wr_ptr[AW-1:0]] <= {wr_ch, conv};
  end

  // FIFO pointer update; simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge PL_clk or negedge PL_USER_RST_N) begin
    if (!PL_USER_RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow flag; a drop in the same cycle wins over clear_ovf.
  always_ff @(posedge PL_clk or negedge PL_USER_RST_N) begin
    if (!PL_USER_RST_N) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
